lif_sweep_scheduler: RTL and testbench

Time-multiplexed controller that shares one leaky-integrate-and-fire update datapath across `N_NEURONS` virtual neurons. It holds per-neuron input current and membrane state in internal register files and, on each `start`, sweeps every neuron once, one per cycle. Spike events go out as neuron indices through a small FIFO with a valid/ready handshake. It sits between the tile's input-current configuration logic and the spike consumer, which is an output pin driver or a downstream neuron layer.

---
 rtl/lif_sweep_scheduler.sv | 198 +++++++++++++++++++
 tb/tb_lif_sweep_scheduler.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lif_sweep_scheduler.sv
// rtl/lif_sweep_scheduler.sv - time-multiplexed leaky-integrate-and-fire sweep controller with spike FIFO
//
// Shares one LIF update datapath across N_NEURONS virtual neurons. Each start
// sweeps every neuron once, one commit per cycle; spiking indices are queued in
// a small FIFO drained through a valid/ready handshake.
//
// Optional feature macro: LIF_REFRACTORY_EN (per-neuron refractory counters).
//
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   cfg_we/cfg_addr/cfg_current write port for the per-neuron input current
//   beta                        leak shift, latched when a sweep starts
//   start                       begin a sweep (IDLE only)
//   busy, done                  sweep in progress / one-cycle completion pulse
//   spike_valid/ready/idx       spike event FIFO head
//   rd_addr, rd_state           combinational membrane-state debug read
module lif_sweep_scheduler #(
    parameter int N_NEURONS     = 8,
    parameter int W             = 8,
    parameter int THRESHOLD     = 200,
    parameter int FIFO_DEPTH    = 4,
    parameter int REFRACT_STEPS = 2,
    localparam int IDXW         = $clog2(N_NEURONS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cfg_we,
    input  logic [IDXW-1:0] cfg_addr,
    input  logic [W-1:0]    cfg_current,
    input  logic [2:0]      beta,
    input  logic            start,
    output logic            busy,
    output logic            done,
    output logic            spike_valid,
    input  logic            spike_ready,
    output logic [IDXW-1:0] spike_idx,
    input  logic [IDXW-1:0] rd_addr,
    output logic [W-1:0]    rd_state
);

    localparam int FAW = $clog2(FIFO_DEPTH);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_UPDATE = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;

    localparam logic [W-1:0]    THR      = W'(THRESHOLD);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N_NEURONS - 1);

    logic [W-1:0]    state_mem   [N_NEURONS];
    logic [W-1:0]    current_mem [N_NEURONS];
    logic [1:0]      fsm;
    logic [IDXW-1:0] idx;
    logic [2:0]      beta_q;

    // Spike FIFO
    logic [IDXW-1:0] fifo_mem [FIFO_DEPTH];
    logic [FAW-1:0]  wr_ptr;
    logic [FAW-1:0]  rd_ptr;
    logic [FAW:0]    count;
    logic            fifo_full;
    logic            pop;
    logic            push;

    // Update datapath
    logic [W:0]   cur_x;
    logic [W:0]   leak;
    logic [W:0]   raw_sum;
    logic [W-1:0] sat_sum;
    logic         fire;
    logic         in_refract;
    logic         spike_req;
    logic         stall;
    logic         commit;
    logic [W-1:0] new_state;

    assign cur_x   = {1'b0, state_mem[idx]};
    assign leak    = cur_x >> beta_q;
    // state - leak is never negative, and the sum fits in W+1 bits
    assign raw_sum = cur_x - leak + {1'b0, current_mem[idx]};
    assign sat_sum = raw_sum[W] ? {W{1'b1}} : raw_sum[W-1:0];
    assign fire    = (sat_sum >= THR);

`ifdef LIF_REFRACTORY_EN
    localparam int RW = (REFRACT_STEPS < 1) ? 1 : $clog2(REFRACT_STEPS + 1);
    logic [RW-1:0] refr_cnt [N_NEURONS];

    assign in_refract = (refr_cnt[idx] != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_NEURONS; i++) begin
                refr_cnt[i] <= '0;
            end
        end else if (commit) begin
            if (in_refract) begin
                refr_cnt[idx] <= refr_cnt[idx] - 1'b1;
            end else if (fire) begin
                refr_cnt[idx] <= RW'(REFRACT_STEPS);
            end
        end
    end
`else
    // No refractory tracking: every neuron is always eligible to update.
    assign in_refract = (REFRACT_STEPS < 0);
`endif

    assign spike_req = (fsm == S_UPDATE) && fire && !in_refract;
    assign new_state = (fire || in_refract) ? '0 : sat_sum;

    assign fifo_full   = (count == (FAW+1)'(FIFO_DEPTH));
    assign spike_valid = (count != '0);
    assign pop         = spike_valid && spike_ready;
    assign spike_idx   = fifo_mem[rd_ptr];

    // A simultaneous pop frees the slot this cycle, so a full FIFO only
    // stalls when nobody is draining it.
    assign stall  = spike_req && fifo_full && !pop;
    assign commit = (fsm == S_UPDATE) && !stall;
    assign push   = spike_req && !stall;

    assign busy     = (fsm != S_IDLE);
    assign done     = (fsm == S_DONE);
    assign rd_state = state_mem[rd_addr];

    // Sweep FSM and neuron index
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm    <= S_IDLE;
            idx    <= '0;
            beta_q <= '0;
        end else begin
            case (fsm)
                S_IDLE: begin
                    if (start) begin
                        fsm    <= S_UPDATE;
                        idx    <= '0;
                        beta_q <= beta;
                    end
                end
                S_UPDATE: begin
                    if (commit) begin
                        idx <= idx + 1'b1;
                        if (idx == LAST_IDX) begin
                            fsm <= S_DONE;
                        end
                    end
                end
                S_DONE:  fsm <= S_IDLE;
                default: fsm <= S_IDLE;
            endcase
        end
    end

    // Register files; the datapath reads the pre-edge current, so a config
    // write to the neuron being updated only takes effect next sweep.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_NEURONS; i++) begin
                state_mem[i]   <= '0;
                current_mem[i] <= '0;
            end
        end else begin
            if (cfg_we) begin
                current_mem[cfg_addr] <= cfg_current;
            end
            if (commit) begin
                state_mem[idx] <= new_state;
            end
        end
    end

    // Spike FIFO
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= idx;
                wr_ptr           <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_lif_sweep_scheduler.sv
// tb/tb_lif_sweep_scheduler.sv - directed self-checking bench for lif_sweep_scheduler
module tb_lif_sweep_scheduler;

    localparam int N    = 8;
    localparam int W    = 8;
    localparam int IDXW = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic            cfg_we;
    logic [IDXW-1:0] cfg_addr;
    logic [W-1:0]    cfg_current;
    logic [2:0]      beta;
    logic            start;
    logic            busy;
    logic            done;
    logic            spike_valid;
    logic            spike_ready;
    logic [IDXW-1:0] spike_idx;
    logic [IDXW-1:0] rd_addr;
    logic [W-1:0]    rd_state;

    int n_checks = 0;
    int n_fails  = 0;
    int done_count = 0;
    int pops[$];

    lif_sweep_scheduler #(
        .N_NEURONS(N), .W(W), .THRESHOLD(200), .FIFO_DEPTH(4), .REFRACT_STEPS(2)
    ) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_current(cfg_current), .beta(beta), .start(start), .busy(busy),
        .done(done), .spike_valid(spike_valid), .spike_ready(spike_ready),
        .spike_idx(spike_idx), .rd_addr(rd_addr), .rd_state(rd_state)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (done === 1'b1) done_count++;
        if (spike_valid === 1'b1 && spike_ready === 1'b1) pops.push_back(int'(spike_idx));
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        pops.delete();
    endtask

    task automatic cfg_write(input int a, input int v);
        @(negedge clk);
        cfg_we = 1'b1;
        cfg_addr = IDXW'(a);
        cfg_current = W'(v);
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic read_state(input int a, output logic [W-1:0] v);
        rd_addr = IDXW'(a);
        #1;
        v = rd_state;
    endtask

    // Counts busy cycles from the current negedge until done is seen.
    task automatic wait_done(output int bc);
        bc = 0;
        for (int i = 0; i < 200; i++) begin
            if (busy) bc++;
            if (done) break;
            @(negedge clk);
        end
        check("sweep_done", 32'(done), 1);
    endtask

    task automatic run_sweep(input logic [2:0] b, output int bc);
        @(negedge clk);
        start = 1'b1;
        beta = b;
        @(negedge clk);
        start = 1'b0;
        wait_done(bc);
        @(negedge clk);
    endtask

    logic [W-1:0] v;
    int bc;
    int d0;
    int exp_sub[6] = '{60, 90, 105, 113, 117, 119};
    int exp_spk;

    initial begin
        rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_current = '0;
        beta = '0; start = 1'b0; spike_ready = 1'b0; rd_addr = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_spike_valid", 32'(spike_valid), 0);
        check("rst_spike_idx", 32'(spike_idx), 0);
        for (int a = 0; a < N; a++) begin
            read_state(a, v);
            check("rst_state", 32'(v), 0);
        end

        // Integrate to spike: 120, 180, then spike
        spike_ready = 1'b1;
        cfg_write(0, 120);
        run_sweep(3'd1, bc);
        check("int_busy_len", 32'(bc), 9);
        read_state(0, v);
        check("int_s1_state", 32'(v), 120);
        run_sweep(3'd1, bc);
        read_state(0, v);
        check("int_s2_state", 32'(v), 180);
        check("int_s2_nospike", 32'(pops.size()), 0);
        @(negedge clk);
        start = 1'b1;
        beta = 3'd1;
        @(negedge clk);
        start = 1'b0;
        check("int_lat_before", 32'(spike_valid), 0);
        @(negedge clk);
        check("int_lat_valid", 32'(spike_valid), 1);
        check("int_lat_idx", 32'(spike_idx), 0);
        wait_done(bc);
        @(negedge clk);
        check("int_s3_count", 32'(pops.size()), 1);
        check("int_s3_idx", 32'(pops[0]), 0);
        read_state(0, v);
        check("int_s3_state", 32'(v), 0);

        // Sub-threshold convergence
        do_reset();
        spike_ready = 1'b1;
        cfg_write(3, 60);
        for (int s = 0; s < 6; s++) begin
            run_sweep(3'd1, bc);
            read_state(3, v);
            check("sub_state", 32'(v), 32'(exp_sub[s]));
        end
        check("sub_nospike", 32'(pops.size()), 0);

        // Backpressure: stall at idx 4, then drain 0..7 in order
        do_reset();
        spike_ready = 1'b0;
        for (int a = 0; a < N; a++) cfg_write(a, 255);
        d0 = done_count;
        @(negedge clk);
        start = 1'b1;
        beta = 3'd0;
        @(negedge clk);
        start = 1'b0;
        repeat (12) @(negedge clk);
        check("bp_busy_held", 32'(busy), 1);
        check("bp_valid", 32'(spike_valid), 1);
        check("bp_head", 32'(spike_idx), 0);
        check("bp_no_done", 32'(done_count), 32'(d0));
        spike_ready = 1'b1;
        wait_done(bc);
        repeat (4) @(negedge clk);
        check("bp_drain_count", 32'(pops.size()), 8);
        for (int i = 0; i < 8; i++) begin
            check("bp_drain_order", 32'(pops[i]), 32'(i));
        end
        check("bp_done_once", 32'(done_count), 32'(d0 + 1));

        // Reset during a stall with 4 entries queued
        do_reset();
        spike_ready = 1'b0;
        for (int a = 0; a < N; a++) cfg_write(a, 255);
        @(negedge clk);
        start = 1'b1;
        beta = 3'd0;
        @(negedge clk);
        start = 1'b0;
        repeat (12) @(negedge clk);
        check("mr_valid_before", 32'(spike_valid), 1);
        d0 = done_count;
        rst = 1'b1;
        #1;
        check("mr_busy", 32'(busy), 0);
        check("mr_done", 32'(done), 0);
        check("mr_valid", 32'(spike_valid), 0);
        check("mr_idx", 32'(spike_idx), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        check("mr_no_done", 32'(done_count), 32'(d0));
        check("mr_idle", 32'(busy), 0);
        for (int a = 0; a < N; a++) begin
            read_state(a, v);
            check("mr_state", 32'(v), 0);
        end
        pops.delete();
        spike_ready = 1'b1;
        run_sweep(3'd0, bc);
        check("mr_currents_cleared", 32'(pops.size()), 0);

        // Mid-sweep config write to neuron 2 and start while busy
        do_reset();
        spike_ready = 1'b1;
        cfg_write(2, 10);
        @(negedge clk);
        start = 1'b1;
        beta = 3'd0;
        @(negedge clk);
        start = 1'b0;
        check("ms_busy", 32'(busy), 1);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cfg_we = 1'b1;
        cfg_addr = 3'd2;
        cfg_current = 8'd50;
        @(negedge clk);
        cfg_we = 1'b0;
        wait_done(bc);
        check("ms_len", 32'(bc), 6);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("ms_start_in_done_ignored", 32'(busy), 0);
        @(negedge clk);
        check("ms_still_idle", 32'(busy), 0);
        read_state(2, v);
        check("ms_old_current", 32'(v), 10);
        run_sweep(3'd0, bc);
        read_state(2, v);
        check("ms_new_current", 32'(v), 50);

        // Refractory behaviour
        do_reset();
        spike_ready = 1'b1;
        cfg_write(1, 255);
        for (int s = 1; s <= 7; s++) begin
            pops.delete();
            run_sweep(3'd0, bc);
            @(negedge clk);
`ifdef LIF_REFRACTORY_EN
            exp_spk = (s % 3 == 1) ? 1 : 0;
`else
            exp_spk = 1;
`endif
            check("refr_spikes", 32'(pops.size()), 32'(exp_spk));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
